// File: rtl/bsg_manycore_print_stat_pkg.sv
// Shared definitions for the print-stat sender and the host-side snoop:
// packet op codes, the print-stat EPA, tag field layout and the sender FSM states.
package bsg_manycore_print_stat_pkg;

  // Word address of the print-stat register in the host EPA space.
  localparam int print_stat_epa_gp = 'h0_0D0C >> 2;

  // Tag layout, decoded by bsg_print_stat_snoop on the host link.
  localparam int print_stat_type_offset_gp       = 0;
  localparam int print_stat_type_width_gp        = 4;
  localparam int print_stat_tile_group_offset_gp = 4;
  localparam int print_stat_tile_group_width_gp  = 14;
  localparam int print_stat_tag_offset_gp        = 18;
  localparam int print_stat_tag_width_gp         = 14;

  typedef enum logic [1:0] {
    e_remote_load  = 2'b00,
    e_remote_store = 2'b01,
    e_remote_amo   = 2'b10,
    e_cache_op     = 2'b11
  } bsg_manycore_packet_op_e;

  typedef enum logic [1:0] {
    e_idle,
    e_drain,
    e_flush_wait,
    e_done
  } print_stat_state_e;

  function automatic int bsg_manycore_packet_width(int addr_w, int data_w, int x_w, int y_w);
    return addr_w + 2 + 4 + 5 + data_w + 2 * x_w + 2 * y_w;
  endfunction

endpackage

// File: rtl/bsg_manycore_print_stat_sender_if.sv
// Tag intake and packet output handshakes of the print-stat sender.
interface bsg_manycore_print_stat_sender_if #(
  parameter int x_cord_width_p = 7,
  parameter int y_cord_width_p = 7,
  parameter int addr_width_p   = 28,
  parameter int data_width_p   = 32,
  localparam int packet_width_lp = bsg_manycore_print_stat_pkg::bsg_manycore_packet_width(
    addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p)
);
  logic                       tag_v_i;
  logic [data_width_p-1:0]    tag_i;
  logic                       tag_ready_o;
  logic                       packet_v_o;
  logic [packet_width_lp-1:0] packet_o;
  logic                       packet_ready_i;

  modport master (
    input  tag_v_i, tag_i, packet_ready_i,
    output tag_ready_o, packet_v_o, packet_o
  );

  modport slave (
    output tag_v_i, tag_i, packet_ready_i,
    input  tag_ready_o, packet_v_o, packet_o
  );
endinterface

// File: rtl/bsg_two_fifo.sv
// Two-entry registered FIFO; ready_o depends only on occupancy, never on yumi_i.
module bsg_two_fifo #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);
  logic [width_p-1:0] mem_reg [2];
  logic               wr_ptr_reg;
  logic               rd_ptr_reg;
  logic [1:0]         count_reg;
  logic               enq;
  logic               deq;

  assign ready_o = (count_reg != 2'd2);
  assign v_o     = (count_reg != 2'd0);
  assign data_o  = mem_reg[rd_ptr_reg];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (enq) wr_ptr_reg <= ~wr_ptr_reg;
      if (deq) rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, enq} - {1'b0, deq};
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk_i) begin
    if (enq) mem_reg[wr_ptr_reg] <= data_i;
  end
endmodule

// File: rtl/bsg_manycore_print_stat_sender.sv
// Turns stat tags into remote stores to the host print-stat EPA, with an
// outstanding-credit limiter and a flush handshake that waits for all returns.
module bsg_manycore_print_stat_sender
  import bsg_manycore_print_stat_pkg::*;
#(
  parameter int x_cord_width_p    = 7,
  parameter int y_cord_width_p    = 7,
  parameter int addr_width_p      = 28,
  parameter int data_width_p      = 32,
  parameter int max_out_credits_p = 16,
  localparam int credit_width_lp  = $clog2(max_out_credits_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [x_cord_width_p-1:0]  my_x_i,
  input  logic [y_cord_width_p-1:0]  my_y_i,
  input  logic [x_cord_width_p-1:0]  host_x_i,
  input  logic [y_cord_width_p-1:0]  host_y_i,
  bsg_manycore_print_stat_sender_if.master link_if,
  input  logic                       credit_return_v_i,
  input  logic                       flush_v_i,
  output logic                       flush_done_o,
  output logic [credit_width_lp-1:0] out_credits_o,
  output logic [31:0]                sent_count_o,
  output logic                       error_o
);
  typedef struct packed {
    logic [addr_width_p-1:0]   addr;
    bsg_manycore_packet_op_e   op;
    logic [3:0]                op_ex;
    logic [4:0]                reg_id;
    logic [data_width_p-1:0]   payload;
    logic [y_cord_width_p-1:0] src_y_cord;
    logic [x_cord_width_p-1:0] src_x_cord;
    logic [y_cord_width_p-1:0] y_cord;
    logic [x_cord_width_p-1:0] x_cord;
  } packet_s;

  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

  print_stat_state_e          state_reg, state_next;
  logic [credit_width_lp-1:0] credits_reg, credits_next;
  logic                       error_reg, error_next;
  logic [31:0]                sent_count_reg;
  logic                       ready_en_reg;
  logic                       fifo_ready, fifo_v;
  logic [data_width_p-1:0]    fifo_data;
  logic                       tag_ready, packet_v, send, flush_done;
  packet_s                    packet_lo;

  bsg_two_fifo #(.width_p(data_width_p)) tag_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (link_if.tag_v_i & tag_ready),
    .data_i    (link_if.tag_i),
    .ready_o   (fifo_ready),
    .v_o       (fifo_v),
    .data_o    (fifo_data),
    .yumi_i    (send)
  );

  always_comb begin
    packet_lo            = '0;
    packet_lo.addr       = addr_width_p'(print_stat_epa_gp);
    packet_lo.op         = e_remote_store;
    packet_lo.op_ex      = 4'b1111;
    packet_lo.reg_id     = 5'd0;
    packet_lo.payload    = fifo_data;
    packet_lo.src_y_cord = my_y_i;
    packet_lo.src_x_cord = my_x_i;
    packet_lo.y_cord     = host_y_i;
    packet_lo.x_cord     = host_x_i;
  end

  // A return that coincides with a send cancels it; a return at full credits is an error.
  always_comb begin
    credits_next = credits_reg;
    error_next   = error_reg;
    if (credit_return_v_i && !send) begin
      if (credits_reg == max_credits_lp) error_next = 1'b1;
      else credits_next = credits_reg + credit_width_lp'(1);
    end else if (send && !credit_return_v_i) begin
      credits_next = credits_reg - credit_width_lp'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    tag_ready  = ready_en_reg & fifo_ready & (state_reg == e_idle);
    packet_v   = fifo_v & (credits_reg != '0) & (state_reg != e_flush_wait);
    flush_done = 1'b0;
    send       = packet_v & link_if.packet_ready_i;
    unique case (state_reg)
      e_idle:       if (flush_v_i) state_next = e_drain;
      e_drain:      if (!fifo_v) state_next = e_flush_wait;
      e_flush_wait: if (credits_next == max_credits_lp) state_next = e_done;
      e_done: begin
        flush_done = 1'b1;
        state_next = e_idle;
      end
      default:      state_next = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg      <= e_idle;
      credits_reg    <= max_credits_lp;
      error_reg      <= 1'b0;
      sent_count_reg <= 32'd0;
      ready_en_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      credits_reg    <= credits_next;
      error_reg      <= error_next;
      ready_en_reg   <= 1'b1;
      if (send) sent_count_reg <= sent_count_reg + 32'd1;
    end
  end

  assign link_if.tag_ready_o = tag_ready;
  assign link_if.packet_v_o  = packet_v;
  assign link_if.packet_o    = packet_lo;
  assign flush_done_o        = flush_done;
  assign out_credits_o       = credits_reg;
  assign sent_count_o        = sent_count_reg;
  assign error_o             = error_reg;
endmodule
